clock_divider_prog: RTL and testbench

//  Runtime-programmable integer clock divider, successor to the fixed-ratio even/odd dividers.

---
 rtl/clock_divider_prog.sv | 146 ++++++++++++++
 tb/tb_clock_divider_prog.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_divider_prog.sv
`default_nettype none
// ============================================================================
// Module   : clock_divider_prog
// Brief    : Runtime-programmable integer clock divider (N = 2 .. 2^C_DIV_W-1)
//            with glitch-free ratio changes at period boundaries.
//            Optional macro CLKDIV_DUTY_ODD50_EN adds a negedge stage that
//            gives exact 50% duty for odd N.
// Revision : 1.0 - initial release
// ============================================================================
module clock_divider_prog #(
  parameter int TCQ       = 1,
  parameter int C_DIV_W   = 8,
  parameter int C_DIV_RST = 9
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic [C_DIV_W-1:0] div_i,
  input  logic               div_load_i,
  output logic               div_ack_o,
  output logic               div_err_o,
  output logic [C_DIV_W-1:0] div_cur_o,
  output logic               tick_o,
  output logic               clk_div_o
);

  localparam logic [C_DIV_W-1:0] c_div_rst = C_DIV_RST[C_DIV_W-1:0];
  localparam logic [C_DIV_W-1:0] c_one     = {{(C_DIV_W-1){1'b0}}, 1'b1};
  localparam logic [C_DIV_W-1:0] c_two     = {{(C_DIV_W-2){1'b0}}, 2'b10};

  typedef enum logic [0:0] {
    S_PARK = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t             r_state;
  logic [C_DIV_W-1:0] r_cnt;
  logic [C_DIV_W-1:0] r_div_cur;
  logic [C_DIV_W-1:0] r_shadow;
  logic               r_pend;
  logic               r_pos_q;
  logic               r_tick;
  logic               r_ack;
  logic               r_err;

  logic               w_load_ok;
  logic               w_last;
  logic               w_apply;
  logic [C_DIV_W-1:0] w_div_next;
  logic [C_DIV_W-1:0] w_half_next;
  logic [C_DIV_W-1:0] w_cnt_next;
  logic               w_unused_tcq;

  assign w_unused_tcq = (TCQ != 0);

  assign w_load_ok = div_load_i && (div_i >= c_two);
  assign w_last    = (r_cnt == (r_div_cur - c_one));

  // Ratio may only change while parked or on the last cycle of a period.
  assign w_apply     = ((r_state == S_PARK) || w_last) && (w_load_ok || r_pend);
  assign w_div_next  = w_apply ? (w_load_ok ? div_i : r_shadow) : r_div_cur;
  assign w_half_next = w_div_next >> 1;
  assign w_cnt_next  = w_last ? '0 : (r_cnt + c_one);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= S_PARK;
      r_cnt     <= '0;
      r_div_cur <= c_div_rst;
      r_shadow  <= c_div_rst;
      r_pend    <= 1'b0;
      r_pos_q   <= 1'b0;
      r_tick    <= 1'b0;
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_ack <= w_apply;
      r_err <= div_load_i && !w_load_ok;

      if (w_apply) begin
        r_div_cur <= w_div_next;
        r_pend    <= 1'b0;
      end else if (w_load_ok) begin
        r_shadow <= div_i;
        r_pend   <= 1'b1;
      end

      case (r_state)
        S_PARK: begin
          r_cnt <= '0;
          if (en_i) begin
            r_state <= S_RUN;
            r_pos_q <= 1'b1;
            r_tick  <= 1'b1;
          end else begin
            r_pos_q <= 1'b0;
            r_tick  <= 1'b0;
          end
        end
        S_RUN: begin
          if (!en_i) begin
            r_state <= S_PARK;
            r_cnt   <= '0;
            r_pos_q <= 1'b0;
            r_tick  <= 1'b0;
          end else begin
            // Outputs are computed for the upcoming count so they stay registered.
            r_cnt   <= w_cnt_next;
            r_pos_q <= (w_cnt_next < w_half_next);
            r_tick  <= (w_cnt_next == '0);
          end
        end
        default: begin
          r_state <= S_PARK;
          r_cnt   <= '0;
          r_pos_q <= 1'b0;
          r_tick  <= 1'b0;
        end
      endcase
    end
  end

`ifdef CLKDIV_DUTY_ODD50_EN
  logic r_neg_q;

  always_ff @(negedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_neg_q <= 1'b0;
    end else begin
      r_neg_q <= r_pos_q;
    end
  end

  // Half-cycle stretch only for odd ratios; even ratios are already balanced.
  assign clk_div_o = r_div_cur[0] ? (r_pos_q | r_neg_q) : r_pos_q;
`else
  assign clk_div_o = r_pos_q;
`endif

  assign div_ack_o = r_ack;
  assign div_err_o = r_err;
  assign div_cur_o = r_div_cur;
  assign tick_o    = r_tick;

endmodule
`default_nettype wire

// File: tb/tb_clock_divider_prog.sv
`default_nettype none
// ============================================================================
// Module   : tb_clock_divider_prog
// Brief    : Scoreboard bench for clock_divider_prog: expected tick/ack/err
//            events are queued by the stimulus and popped by a monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clock_divider_prog;

  logic       clk_i;
  logic       rst_i;
  logic       en_i;
  logic [7:0] div_i;
  logic       div_load_i;
  logic       div_ack_o;
  logic       div_err_o;
  logic [7:0] div_cur_o;
  logic       tick_o;
  logic       clk_div_o;

  clock_divider_prog #(
    .TCQ       (1),
    .C_DIV_W   (8),
    .C_DIV_RST (9)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .en_i       (en_i),
    .div_i      (div_i),
    .div_load_i (div_load_i),
    .div_ack_o  (div_ack_o),
    .div_err_o  (div_err_o),
    .div_cur_o  (div_cur_o),
    .tick_o     (tick_o),
    .clk_div_o  (clk_div_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // mask bit 0 = tick, 1 = ack, 2 = err; gap/hi < 0 means don't care
  typedef struct {
    logic [2:0] mask;
    int         gap;
    int         hi;
    logic [7:0] cur;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  int   last_tick   = 0;
  int   hi_acc      = 0;

  localparam logic [2:0] c_tick = 3'b001;
  localparam logic [2:0] c_ack_tick = 3'b011;
  localparam logic [2:0] c_err = 3'b100;

  // High time of one period in half clk_i cycles.
  function automatic int exp_hi(input int n);
`ifdef CLKDIV_DUTY_ODD50_EN
    return n;
`else
    return (n % 2 == 1) ? n - 1 : n;
`endif
  endfunction

  task automatic push(input logic [2:0] m, input int g, input int h, input logic [7:0] c);
    exp_t e;
    e.mask = m;
    e.gap  = g;
    e.hi   = h;
    e.cur  = c;
    sb.push_back(e);
  endtask

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Monitor: samples 1 time unit after each clock edge.
  initial begin
    logic [2:0] act;
    int         meas_gap;
    int         meas_hi;
    exp_t       e;
    meas_gap = 0;
    meas_hi  = 0;
    forever begin
      @(posedge clk_i);
      cyc++;
      #1;
      if (tick_o) begin
        meas_gap  = cyc - last_tick;
        meas_hi   = hi_acc;
        last_tick = cyc;
        hi_acc    = 0;
      end
      hi_acc = hi_acc + (clk_div_o ? 1 : 0);
      if (tick_o || div_ack_o || div_err_o) begin
        act = {div_err_o, div_ack_o, tick_o};
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_event cyc=%0d: got mask=%b cur=%0d, required no event",
                   cyc, act, div_cur_o);
        end else begin
          e = sb.pop_front();
          if (act != e.mask || div_cur_o != e.cur ||
              (tick_o && e.gap >= 0 && meas_gap != e.gap) ||
              (tick_o && e.hi >= 0 && meas_hi != e.hi)) begin
            miscompares++;
            $display("FAIL event cyc=%0d: got mask=%b cur=%0d gap=%0d hi_halves=%0d, required mask=%b cur=%0d gap=%0d hi_halves=%0d",
                     cyc, act, div_cur_o, meas_gap, meas_hi, e.mask, e.cur, e.gap, e.hi);
          end
        end
      end
      @(negedge clk_i);
      #1;
      hi_acc = hi_acc + (clk_div_o ? 1 : 0);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk_i);
    #3;
  endtask

  task automatic wait_tick();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clk_i);
      #1;
      if (tick_o) seen = 1'b1;
    end
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("FAIL tick_timeout: got no tick_o in 100 cycles, required a tick");
    end
    #2;
  endtask

  task automatic pulse_load(input logic [7:0] v);
    div_i      = v;
    div_load_i = 1'b1;
    @(posedge clk_i);
    #3;
    div_load_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i      = 1'b1;
    en_i       = 1'b0;
    div_i      = 8'd0;
    div_load_i = 1'b0;

    step(2);
    check("reset_outputs", {tick_o, div_ack_o, div_err_o, clk_div_o, div_cur_o}, {4'b0000, 8'd9});
    rst_i = 1'b0;
    step(1);

    // T1: default ratio 9
    push(c_tick, -1, -1, 8'd9);
    repeat (3) push(c_tick, 9, exp_hi(9), 8'd9);
    en_i = 1'b1;
    repeat (4) wait_tick();

    // T3: illegal ratios rejected
    push(c_err, -1, -1, 8'd9);
    push(c_err, -1, -1, 8'd9);
    push(c_tick, 9, exp_hi(9), 8'd9);
    pulse_load(8'd1);
    pulse_load(8'd0);
    wait_tick();

    // T2: load 4 mid-period, applied at boundary
    push(c_ack_tick, 9, exp_hi(9), 8'd4);
    repeat (2) push(c_tick, 4, exp_hi(4), 8'd4);
    pulse_load(8'd4);
    repeat (3) wait_tick();

    // T4: back-to-back loads, last wins
    push(c_ack_tick, 4, exp_hi(4), 8'd3);
    repeat (2) push(c_tick, 3, exp_hi(3), 8'd3);
    pulse_load(8'd6);
    pulse_load(8'd3);
    repeat (3) wait_tick();

    // Load in the boundary cycle bypasses the shadow
    push(c_ack_tick, 3, exp_hi(3), 8'd2);
    repeat (2) push(c_tick, 2, exp_hi(2), 8'd2);
    step(2);
    pulse_load(8'd2);
    repeat (2) wait_tick();

    // T5: disable mid-period, then re-enable
    en_i = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    #1;
    check("park_clk_low", clk_div_o, 0);
    step(3);
    push(c_tick, -1, -1, 8'd2);
    en_i = 1'b1;
    @(posedge clk_i);
    #1;
    check("restart_clk_high", clk_div_o, 1);
    #2;

    // T6: async reset with a pending load
    pulse_load(8'd5);
    #4;
    rst_i = 1'b1;
    #1;
    check("async_reset_outputs", {tick_o, div_ack_o, div_err_o, clk_div_o, div_cur_o}, {4'b0000, 8'd9});
    repeat (2) @(posedge clk_i);
    #3;
    push(c_tick, -1, -1, 8'd9);
    push(c_tick, 9, exp_hi(9), 8'd9);
    rst_i = 1'b0;
    repeat (2) wait_tick();

    en_i = 1'b0;
    step(4);
    check("scoreboard_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
